fifo_pkt_framer: RTL and testbench
==================================

FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width and header width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, upstream FIFO address width; fifo_count is ADDR_WIDTH+1 bits.
REQ-003 SHALL have parameter MAX_PKT, default 16, maximum payload words per packet; legal range 1..min(2^WIDTH-1, 2^ADDR_WIDTH).
REQ-004 SHALL have parameter TIMEOUT, default 32, idle cycles before a short packet is flushed; legal range >=1.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_count  input  ADDR_WIDTH+1  upstream FIFO occupancy.
REQ-009 fifo_data  input  WIDTH  upstream FIFO head word, show-ahead, valid when !fifo_empty.
REQ-010 fifo_rd_en  output  1  pop request to upstream FIFO.
REQ-011 m_valid  output  1  output word valid.
REQ-012 m_ready  input  1  downstream accepts word.
REQ-013 m_data  output  WIDTH  output word.
REQ-014 m_sop / m_eop  output  1 each  first / last word of packet.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 pkt_count  output  16  completed packets, wraps modulo 2^16.

Function
REQ-017 SHALL implement FSM states IDLE, HDR, PAYLOAD, CKSUM (CKSUM reachable only with macro).
REQ-018 IDLE->HDR when fifo_count >= MAX_PKT, or when !fifo_empty and idle timer == TIMEOUT-1; on that edge latch len = min(fifo_count, MAX_PKT), clear remaining counter to len.
REQ-019 Idle timer SHALL count up in IDLE while !fifo_empty and fifo_count < MAX_PKT, saturate at TIMEOUT-1, clear to 0 when fifo_empty or on leaving IDLE.
REQ-020 HDR: m_valid=1, m_sop=1, m_eop=0, m_data=len zero-extended; HDR->PAYLOAD on m_ready.
REQ-021 PAYLOAD: m_valid = !fifo_empty, m_data = fifo_data, m_sop=0, m_eop = (remaining==1) without macro.
REQ-022 fifo_rd_en = PAYLOAD && m_valid && m_ready; combinational; never asserted when fifo_empty (no upstream underflow).
REQ-023 Each accepted payload word SHALL decrement remaining; on last word PAYLOAD->IDLE (or ->CKSUM with macro).
REQ-024 A packet SHALL complete on its eop handshake; pkt_count increments by 1 on that edge.
REQ-025 While m_valid && !m_ready, m_data, m_sop, m_eop SHALL hold stable (upstream head is not popped).
REQ-026 Words arriving upstream during a packet SHALL NOT extend it; length is fixed at latch time.
REQ-027 Back-to-back: IDLE re-evaluates start condition on the cycle after return; no bubble otherwise required.
REQ-028 Zero-cycle latency: fifo_data to m_data combinational in PAYLOAD; header first visible one cycle after start condition.

Reset
REQ-029 On rst_n low: state=IDLE, timer=0, remaining=0, pkt_count=0, checksum=0; m_valid=0, fifo_rd_en=0, m_sop=0, m_eop=0, busy=0, m_data=0.
REQ-030 Reset mid-packet SHALL abandon the packet immediately; no eop emitted; unread FIFO words remain upstream.

Configuration
REQ-031 Macro FIFO_PKT_CHECKSUM_EN defined: running XOR of payload words (cleared in HDR); after last payload go to CKSUM, emit XOR with m_eop=1, m_eop=0 on last payload; CKSUM->IDLE on m_ready.
REQ-032 Macro undefined: no CKSUM state or checksum register; eop on last payload word.

Structure
REQ-033 Package fifo_pkt_pkg SHALL hold the FSM state enum and the header-encode helper constant widths.
REQ-034 One sub-module pkt_idle_timer (saturating timer, clear/enable/done) is natural; everything else in fifo_pkt_framer.

Verification
REQ-035 Push 16 words 0x01..0x10, m_ready=1 -> header 0x10 with sop, words 0x01..0x10, eop on 0x10, pkt_count=1.
REQ-036 Push 3 words 0xA0..0xA2 then stop -> after 32 idle cycles header 0x03, 3 payload words, eop on 0xA2.
REQ-037 40 words buffered, m_ready=1 -> packets of 16,16,8 (last after timeout), pkt_count=3, fifo_rd_en never with fifo_empty.
REQ-038 m_ready toggling every cycle during payload -> m_data/m_eop stable while stalled, no word lost or duplicated.
REQ-039 Assert rst_n low after 5 of 16 payload words -> all outputs reset values next sample, 11 words remain upstream.
REQ-040 With FIFO_PKT_CHECKSUM_EN, payload 0x01,0x02,0x04 (timeout) -> trailer 0x07 with eop, payload eop=0.

Source files
------------

// File: rtl/fifo_pkt_pkg.sv
// Shared types for the FIFO packet framer: FSM state encoding and counter widths.
// The CKSUM state exists only when FIFO_PKT_CHECKSUM_EN is defined.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
`ifdef FIFO_PKT_CHECKSUM_EN
        ST_PAYLOAD = 2'd2,
        ST_CKSUM   = 2'd3
`else
        ST_PAYLOAD = 2'd2
`endif
    } state_e;

    localparam int PKT_COUNT_W = 16;

endpackage

// File: rtl/pkt_idle_timer.sv
// Saturating idle timer: counts while enabled, holds at TIMEOUT-1, clears on clr_i.
// done_o is high while the count sits at TIMEOUT-1.
module pkt_idle_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: clear has priority, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_pkt_framer.sv
// Frames words from a show-ahead FIFO into packets: length header, payload, optional XOR trailer.
// Define FIFO_PKT_CHECKSUM_EN to append the XOR checksum word carrying m_eop.
module fifo_pkt_framer
    import fifo_pkt_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_PKT    = 16,
    parameter int TIMEOUT    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    input  logic [ADDR_WIDTH:0]     fifo_count,
    input  logic [WIDTH-1:0]        fifo_data,
    output logic                    fifo_rd_en,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_sop,
    output logic                    m_eop,
    output logic                    busy,
    output logic [PKT_COUNT_W-1:0]  pkt_count
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PKT);

    state_e                  state_q, state_d;
    logic [CW-1:0]           len_q, len_d;
    logic [CW-1:0]           rem_q, rem_d;
    logic [PKT_COUNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic                    timer_done_s;
    logic                    start_s;
    logic                    below_max_s;

    assign below_max_s = (fifo_count < MAX_C);
    assign start_s     = (state_q == ST_IDLE) &&
                         (!below_max_s || (!fifo_empty && timer_done_s));

    pkt_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  ((state_q != ST_IDLE) || fifo_empty || start_s),
        .en_i   ((state_q == ST_IDLE) && !fifo_empty && below_max_s),
        .done_o (timer_done_s)
    );

`ifdef FIFO_PKT_CHECKSUM_EN
    logic [WIDTH-1:0] cksum_q, cksum_d;

    // Running XOR of popped payload words, restarted while the header is shown.
    always_comb begin
        cksum_d = cksum_q;
        if (state_q == ST_HDR) begin
            cksum_d = '0;
        end else if (fifo_rd_en) begin
            cksum_d = cksum_q ^ fifo_data;
        end else begin
            cksum_d = cksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end
`endif

    // FSM next state and the combinational stream outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        m_valid    = 1'b0;
        m_sop      = 1'b0;
        m_eop      = 1'b0;
        m_data     = '0;
        fifo_rd_en = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_s) begin
                    state_d = ST_HDR;
                    len_d   = below_max_s ? fifo_count : MAX_C;
                    rem_d   = below_max_s ? fifo_count : MAX_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                m_valid = 1'b1;
                m_sop   = 1'b1;
                m_data  = WIDTH'(len_q);
                if (m_ready) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                m_valid    = !fifo_empty;
                m_data     = fifo_data;
`ifdef FIFO_PKT_CHECKSUM_EN
                m_eop      = 1'b0;
`else
                m_eop      = (rem_q == CW'(1));
`endif
                // Pop only when a word is actually handed downstream.
                fifo_rd_en = !fifo_empty && m_ready;
                if (fifo_rd_en) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
`ifdef FIFO_PKT_CHECKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
`ifdef FIFO_PKT_CHECKSUM_EN
            ST_CKSUM: begin
                m_valid = 1'b1;
                m_eop   = 1'b1;
                m_data  = cksum_q;
                if (m_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CKSUM;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy    = 1'b0;
            end
        endcase
    end

    // Completed-packet counter advances on the eop handshake.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (m_valid && m_ready && m_eop) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rem_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer: bench-side FIFO queue, packet-stream reference model, scenario tasks.
// Compile with FIFO_PKT_CHECKSUM_EN to exercise the checksum trailer.
module tb_fifo_pkt_framer;

    localparam int MAX_PKT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [6:0]  fifo_count;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sop;
    logic        m_eop;
    logic        busy;
    logic [15:0] pkt_count;

    int checks   = 0;
    int failures = 0;
    int exp_pkts = 0;

    logic [7:0] fq[$];
    logic [7:0] pushed[$];
    logic [9:0] out_q[$];
    logic [9:0] exp_q[$];

    logic       o_valid, o_sop, o_eop, o_rd, o_busy;
    logic [7:0] o_data;
    logic       p_valid = 1'b0, p_ready = 1'b0, p_sop = 1'b0, p_eop = 1'b0;
    logic [7:0] p_data = 8'h00;

    fifo_pkt_framer #(
        .WIDTH(8), .ADDR_WIDTH(6), .MAX_PKT(MAX_PKT), .TIMEOUT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
        .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic push_word(input logic [7:0] w);
        fq.push_back(w);
        pushed.push_back(w);
    endtask

    // Expected stream: chunks of min(left, MAX_PKT), each a length header then its words.
    task automatic build_model();
        int idx = 0;
        int n = pushed.size();
        exp_q.delete();
        while (idx < n) begin
            int len = (n - idx < MAX_PKT) ? (n - idx) : MAX_PKT;
            logic [7:0] x = 8'h00;
            exp_q.push_back({8'(len), 1'b1, 1'b0});
            for (int j = 0; j < len; j++) begin
                x = x ^ pushed[idx + j];
`ifdef FIFO_PKT_CHECKSUM_EN
                exp_q.push_back({pushed[idx + j], 1'b0, 1'b0});
`else
                exp_q.push_back({pushed[idx + j], 1'b0, (j == len - 1)});
`endif
            end
`ifdef FIFO_PKT_CHECKSUM_EN
            exp_q.push_back({x, 1'b0, 1'b1});
`endif
            exp_pkts++;
            idx += len;
        end
        pushed.delete();
    endtask

    task automatic step(input logic rdy);
        @(negedge clk);
        m_ready    = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_count = 7'(fq.size());
        fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
        #1;
        o_valid = m_valid; o_data = m_data; o_sop = m_sop; o_eop = m_eop;
        o_rd = fifo_rd_en; o_busy = busy;
        checks++;
        if (o_rd && fifo_empty) begin
            failures++;
            $display("FAIL rd_when_empty: fifo_rd_en=%0b with fifo_empty=%0b, required rd_en=0", o_rd, fifo_empty);
        end
        if (p_valid && !p_ready) begin
            checks++;
            if (!o_valid || o_data !== p_data || o_sop !== p_sop || o_eop !== p_eop) begin
                failures++;
                $display("FAIL stall_hold: got v=%0b d=%02h s=%0b e=%0b, required v=1 d=%02h s=%0b e=%0b",
                         o_valid, o_data, o_sop, o_eop, p_data, p_sop, p_eop);
            end
        end
        if (o_valid && rdy) out_q.push_back({o_data, o_sop, o_eop});
        p_valid = o_valid; p_ready = rdy; p_data = o_data; p_sop = o_sop; p_eop = o_eop;
        @(posedge clk);
        if (o_rd) void'(fq.pop_front());
    endtask

    // mode 0: ready always, 1: ready toggles every cycle, 2: random ready.
    task automatic drain(input int mode);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 3000) begin
            logic rdy;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (n % 2 == 0);
            else rdy = 1'($urandom_range(0, 1));
            step(rdy);
            n++;
            if (!o_busy && !o_valid && fq.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: busy=%0b fifo_words=%0d, required idle and empty", o_busy, fq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_count = 7'd0; fifo_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({m_valid, m_sop, m_eop, fifo_rd_en, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: v/s/e/rd/busy=%05b, required 00000", {m_valid, m_sop, m_eop, fifo_rd_en, busy});
        end
        checks++;
        if (m_data !== 8'h00 || pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_data: m_data=%02h pkt_count=%0d, required 00 and 0", m_data, pkt_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_packet();
        out_q.delete();
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        build_model();
        drain(0);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL full_len: got %0d words, required %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL full_word[%0d]: got %03h, required %03h", i, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            failures++;
            $display("FAIL full_pkt_count: got %0d, required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_timeout();
        int first = -1;
        out_q.delete();
        for (int i = 0; i < 3; i++) push_word(8'hA0 + 8'(i));
        build_model();
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (o_valid && first < 0) first = i;
        end
        drain(0);
        checks++;
        if (first != 32) begin
            failures++;
            $display("FAIL timeout_latency: header at cycle %0d, required 32", first);
        end
        checks++;
        if (out_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL timeout_len: got %0d words, required %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL timeout_word[%0d]: got %03h, required %03h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    // mode picks the ready pattern; extra>0 pushes that many more words mid-packet.
    task automatic test_stream(input string name, input int nwords, input int mode, input int extra);
        out_q.delete();
        for (int i = 0; i < nwords; i++) push_word(8'($urandom));
        if (extra > 0) begin
            repeat (4) step(1'b1);
            for (int i = 0; i < extra; i++) push_word(8'($urandom));
        end
        build_model();
        drain(mode);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len: got %0d words, required %0d", name, out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word[%0d]: got %03h, required %03h", name, i, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            failures++;
            $display("FAIL %s_pkt_count: got %0d, required %0d", name, pkt_count, exp_pkts);
        end
    endtask

    task automatic test_midpacket_reset();
        int payload = 0;
        int n = 0;
        out_q.delete();
        for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
        pushed.delete();
        while (payload < 5 && n < 200) begin
            step(1'b1);
            if (o_valid && !o_sop) payload++;
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_sop, m_eop, fifo_rd_en, busy} !== 5'b0 || m_data !== 8'h00) begin
            failures++;
            $display("FAIL midreset_outputs: v/s/e/rd/busy=%05b data=%02h, required 00000 and 00",
                     {m_valid, m_sop, m_eop, fifo_rd_en, busy}, m_data);
        end
        checks++;
        if (pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL midreset_pkt_count: got %0d, required 0", pkt_count);
        end
        checks++;
        if (fq.size() != 11) begin
            failures++;
            $display("FAIL midreset_left: %0d words upstream, required 11", fq.size());
        end
        fq.delete();
        fifo_empty = 1'b1; fifo_count = 7'd0; fifo_data = 8'h00;
        exp_pkts = 0;
        p_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef FIFO_PKT_CHECKSUM_EN
    task automatic test_checksum();
        out_q.delete();
        push_word(8'h01); push_word(8'h02); push_word(8'h04);
        build_model();
        drain(0);
        checks++;
        if (out_q.size() != 5 || out_q[4] !== {8'h07, 1'b0, 1'b1} || out_q[3] !== {8'h04, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL checksum_trailer: got %0d words last=%03h, required 5 words last=01d", out_q.size(),
                     (out_q.size() > 0) ? out_q[out_q.size() - 1] : 10'h0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_packet();
        test_timeout();
        test_stream("back_to_back", 40, 0, 0);
        test_stream("stall_toggle", 20, 1, 0);
        test_stream("grow_midpkt", 16, 0, 5);
        for (int k = 0; k < 3; k++) test_stream("random", $urandom_range(1, 50), 2, 0);
        test_midpacket_reset();
        test_stream("after_reset", 18, 2, 0);
`ifdef FIFO_PKT_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
